// File: rtl/rv32i_decode_alu_if.sv
// Decode/ALU bus bundle: instruction fields out, ALU operands in, registered result out.
interface rv32i_decode_alu_if;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [2:0]  func;
  logic        alt;
  logic [31:0] result;

  modport master (
    output inst, lhs, rhs, func, alt,
    input  opcode, rd, funct3, rs1, rs2, funct7, imm, illegal, result
  );

  modport slave (
    input  inst, lhs, rhs, func, alt,
    output opcode, rd, funct3, rs1, rs2, funct7, imm, illegal, result
  );
endinterface

// File: rtl/rv32i_decode_alu.sv
// RV32I combinational decoder plus ALU with 1-cycle registered result, no backpressure.
// Optional macro RV32I_ILLEGAL_DETECT_EN enables the illegal-instruction flag.
module rv32i_decode_alu #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  rv32i_decode_alu_if.slave bus
);

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  logic [31:0]     w_inst;
  logic [31:0]     w_imm;
  logic [XLEN-1:0] w_alu;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] r_result;

  assign w_inst     = bus.inst;
  assign bus.opcode = w_inst[6:0];
  assign bus.rd     = w_inst[11:7];
  assign bus.funct3 = w_inst[14:12];
  assign bus.rs1    = w_inst[19:15];
  assign bus.rs2    = w_inst[24:20];
  assign bus.funct7 = w_inst[31:25];
  assign bus.imm    = w_imm;

  always_comb begin
    w_imm = '0;
    case (w_inst[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR:
        w_imm = {{20{w_inst[31]}}, w_inst[31:20]};
      OP_STORE:
        w_imm = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      OP_BRANCH:
        w_imm = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        w_imm = {w_inst[31:12], 12'b0};
      OP_JAL:
        w_imm = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

`ifdef RV32I_ILLEGAL_DETECT_EN
  logic w_known_op;
  logic w_bad_funct7;

  always_comb begin
    w_known_op = 1'b0;
    case (w_inst[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI,
      OP_AUIPC, OP_JAL, OP_OP, OP_MISC_MEM, OP_SYSTEM: w_known_op = 1'b1;
      default: w_known_op = 1'b0;
    endcase
  end

  // 0100000 is only meaningful for SUB and SRA
  always_comb begin
    w_bad_funct7 = 1'b0;
    if (w_inst[6:0] == OP_OP) begin
      if (w_inst[31:25] == 7'b0000000)
        w_bad_funct7 = 1'b0;
      else if (w_inst[31:25] == 7'b0100000 &&
               (w_inst[14:12] == 3'b000 || w_inst[14:12] == 3'b101))
        w_bad_funct7 = 1'b0;
      else
        w_bad_funct7 = 1'b1;
    end
  end

  assign bus.illegal = !w_known_op || (w_inst[1:0] != 2'b11) || w_bad_funct7;
`else
  assign bus.illegal = 1'b0;
`endif

  assign w_shamt = bus.rhs[4:0];

  always_comb begin
    w_alu = '0;
    case (bus.func)
      3'b000: w_alu = bus.alt ? (bus.lhs - bus.rhs) : (bus.lhs + bus.rhs);
      3'b001: w_alu = bus.lhs << w_shamt;
      3'b010: w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.lhs) < $signed(bus.rhs))};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, (bus.lhs < bus.rhs)};
      3'b100: w_alu = bus.lhs ^ bus.rhs;
      3'b101: w_alu = bus.alt ? XLEN'($signed(bus.lhs) >>> w_shamt) : (bus.lhs >> w_shamt);
      3'b110: w_alu = bus.lhs | bus.rhs;
      3'b111: w_alu = bus.lhs & bus.rhs;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_result <= '0;
    else
      r_result <= w_alu;
  end

  assign bus.result = r_result;

endmodule

// File: tb/tb_rv32i_decode_alu.sv
// Bench for rv32i_decode_alu: directed plan vectors plus randomized encode/decode and ALU streaming.
module tb_rv32i_decode_alu;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  rv32i_decode_alu_if bus ();

  rv32i_decode_alu #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ALU reference evaluated in 64-bit signed/unsigned integer arithmetic
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic alt);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'({{32{a[31]}}, a});
    longint sb = longint'({{32{b[31]}}, b});
    longint p2 = longint'(1) << (ub % 32);
    case (f)
      3'd0: return alt ? 32'(ua - ub) : 32'(ua + ub);
      3'd1: return 32'(ua * p2);
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (ua < ub) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (alt) begin
          // floor division toward minus infinity for negative values
          if (sa < 0) return 32'(-((-sa + p2 - 1) / p2));
          return 32'(sa / p2);
        end
        return 32'(ua / p2);
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
`ifdef RV32I_ILLEGAL_DETECT_EN
    logic [6:0] legal [11] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73};
    logic known = 1'b0;
    logic [6:0] op = i[6:0];
    logic [6:0] f7 = i[31:25];
    logic [2:0] f3 = i[14:12];
    foreach (legal[k]) if (legal[k] == op) known = 1'b1;
    if (!known || i[1:0] != 2'b11) return 1'b1;
    if (op == 7'h33) begin
      if (f7 == 7'h00) return 1'b0;
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return 1'b0;
      return 1'b1;
    end
    return 1'b0;
`else
    return (i == 32'hFFFF_FFFF) && (i != 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic check_fields(input string tag, input logic [31:0] i, input logic [31:0] exp_imm);
    #1;
    check({tag, ".opcode"}, {25'b0, bus.opcode}, i % 128);
    check({tag, ".rd"},     {27'b0, bus.rd},     (i / 128) % 32);
    check({tag, ".funct3"}, {29'b0, bus.funct3}, (i / 4096) % 8);
    check({tag, ".rs1"},    {27'b0, bus.rs1},    (i / 32768) % 32);
    check({tag, ".rs2"},    {27'b0, bus.rs2},    (i / 1048576) % 32);
    check({tag, ".funct7"}, {25'b0, bus.funct7}, i / 33554432);
    check({tag, ".imm"},    bus.imm,             exp_imm);
    check({tag, ".illegal"}, {31'b0, bus.illegal}, {31'b0, ref_illegal(i)});
  endtask

  task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f, input logic alt, input logic rst,
                        input logic use_exp, input logic [31:0] exp);
    logic [31:0] e;
    @(negedge clk);
    bus.lhs = a; bus.rhs = b; bus.func = f; bus.alt = alt; reset = rst;
    e = rst ? 32'd0 : (use_exp ? exp : ref_alu(a, b, f, alt));
    @(posedge clk);
    #1;
    check(tag, bus.result, e);
  endtask

  initial begin
    logic [31:0] i, v, e;
    logic [6:0]  op;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [6:0]  others [4] = '{7'h33, 7'h0F, 7'h73, 7'h5B};
    logic [6:0]  itype [3] = '{7'h03, 7'h13, 7'h67};
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.inst = 32'h0; bus.lhs = 32'h0; bus.rhs = 32'h0; bus.func = 3'd0; bus.alt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.result, 32'd0);

    bus.inst = 32'hFFF10093; check_fields("addi", bus.inst, 32'hFFFFFFFF);
    bus.inst = 32'h123452B7; check_fields("lui", bus.inst, 32'h12345000);
    bus.inst = 32'hFFDFF0EF; check_fields("jal", bus.inst, 32'hFFFFFFFC);
    bus.inst = 32'h00000000; check_fields("zero_inst", bus.inst, 32'h0);
`ifdef RV32I_ILLEGAL_DETECT_EN
    check("illegal_zero", {31'b0, bus.illegal}, 32'd1);
`endif

    // encode a known immediate into each format and expect it decoded back
    for (int n = 0; n < 60; n++) begin
      v  = $urandom;
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); f3 = 3'($urandom);
      case (n % 7)
        0: begin op = itype[$urandom_range(0, 2)];
                 e = 32'($signed(v[11:0])); i = {v[11:0], r1, f3, rd, op}; end
        1: begin op = 7'h23; e = 32'($signed(v[11:0]));
                 i = {v[11:5], r2, r1, f3, v[4:0], op}; end
        2: begin op = 7'h63; e = 32'($signed({v[12:1], 1'b0}));
                 i = {e[12], e[10:5], r2, r1, f3, e[4:1], e[11], op}; end
        3: begin op = ($urandom_range(0, 1) != 0) ? 7'h37 : 7'h17;
                 e = {v[31:12], 12'b0}; i = {v[31:12], rd, op}; end
        4: begin op = 7'h6F; e = 32'($signed({v[20:1], 1'b0}));
                 i = {e[20], e[10:1], e[11], e[19:12], rd, op}; end
        5: begin op = others[$urandom_range(0, 3)]; e = 32'd0;
                 i = {v[31:12], rd, op}; end
        default: begin
                 op = others[0]; e = 32'd0;
                 i = {(($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00), r2, r1, f3, rd, op}; end
      endcase
      bus.inst = i;
      check_fields("rand_dec", i, e);
    end

    alu_op("sub_5_7",    32'd5,        32'd7,        3'd0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE);
    alu_op("add_wrap",   32'hFFFFFFFF, 32'd1,        3'd0, 1'b0, 1'b0, 1'b1, 32'h0);
    alu_op("sra",        32'h80000000, 32'd4,        3'd5, 1'b1, 1'b0, 1'b1, 32'hF8000000);
    alu_op("srl",        32'h80000000, 32'd4,        3'd5, 1'b0, 1'b0, 1'b1, 32'h08000000);
    alu_op("sll_33",     32'd1,        32'd33,       3'd1, 1'b0, 1'b0, 1'b1, 32'd2);
    alu_op("sll_0",      32'h89ABCDEF, 32'd0,        3'd1, 1'b0, 1'b0, 1'b1, 32'h89ABCDEF);
    alu_op("sra_0",      32'h89ABCDEF, 32'd32,       3'd5, 1'b1, 1'b0, 1'b1, 32'h89ABCDEF);
    alu_op("slt_m1",     32'hFFFFFFFF, 32'd1,        3'd2, 1'b0, 1'b0, 1'b1, 32'd1);
    alu_op("sltu_m1",    32'hFFFFFFFF, 32'd1,        3'd3, 1'b0, 1'b0, 1'b1, 32'd0);
    alu_op("slt_bound",  32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b0, 1'b0, 1'b1, 32'd1);
    alu_op("sltu_bound", 32'h80000000, 32'h7FFFFFFF, 3'd3, 1'b0, 1'b0, 1'b1, 32'd0);
    alu_op("xor_alt",    32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 1'b1, 1'b0, 1'b1, 32'hFF00FF00);
    alu_op("or",         32'hF0F0F0F0, 32'h0FF00FF0, 3'd6, 1'b0, 1'b0, 1'b1, 32'hFFF0FFF0);
    alu_op("and_alt",    32'hF0F0F0F0, 32'h0FF00FF0, 3'd7, 1'b1, 1'b0, 1'b1, 32'h00F000F0);

    for (int n = 0; n < 200; n++) begin
      v = $urandom;
      if (n % 4 == 0) v = 32'($urandom_range(0, 40));
      alu_op("rand_alu", $urandom, v, 3'($urandom), 1'($urandom), 1'b0, 1'b0, 32'd0);
    end

    alu_op("pre_reset",   32'd100, 32'd23, 3'd0, 1'b0, 1'b0, 1'b1, 32'd123);
    alu_op("mid_reset",   32'd100, 32'd23, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    alu_op("after_reset", 32'd9,   32'd4,  3'd1, 1'b0, 1'b0, 1'b1, 32'd144);
    alu_op("stream_next", 32'd9,   32'd4,  3'd0, 1'b1, 1'b0, 1'b1, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv32i_decode_alu.md
Name: rv32i_decode_alu

Overview:
- Combined RV32I instruction decoder and integer ALU for the core's execute path.
- Decoder is purely combinational. It splits a 32-bit instruction into opcode, funct fields and register indices, and produces the sign-extended immediate.
- ALU computes the RV32I OP/OP-IMM function selected by funct3 plus an alternate-operation flag. Its result is registered with 1-cycle latency.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- inst  in  32  instruction word to decode
- opcode  out  7  inst[6:0]
- rd  out  5  inst[11:7]
- funct3  out  3  inst[14:12]
- rs1  out  5  inst[19:15]
- rs2  out  5  inst[24:20]
- funct7  out  7  inst[31:25]
- imm  out  32  sign-extended immediate for the instruction format
- illegal  out  1  unknown opcode flag; see Optional Feature
- lhs  in  32  ALU operand A
- rhs  in  32  ALU operand B
- func  in  3  ALU function (RV32I funct3 encoding)
- alt  in  1  alternate op: SUB instead of ADD, SRA instead of SRL
- result  out  32  registered ALU result

Behaviour:
- Interface: clock clk; reset is reset, synchronous, active-high.
- Decoder field outputs are combinational in the same cycle, with no state. They are always driven, even for unknown opcodes.
- imm selection by opcode (all immediates sign-extended from inst[31]):
  - I-type {inst[31:20]}: LOAD 0000011, OP_IM 0010011, JALR 1100111.
  - S-type {inst[31:25],inst[11:7]}: STORE 0100011.
  - B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}: BRANCH 1100011.
  - U-type {inst[31:12],12'b0}: LUI 0110111, AUIPC 0010111.
  - J-type {inst[31],inst[19:12],inst[20],inst[30:21],0}: JAL 1101111.
  - All other opcodes (OP 0110011, MISC_MEM 0001111, SYSTEM 1110011, unknown): imm = 0.
- For OP_IM shifts, imm is plain I-type. The caller drives alt; the ALU uses only rhs[4:0] as shamt.
- ALU functions, by func:
  - 000: ADD, or SUB (lhs-rhs) when alt=1.
  - 001: SLL, shamt rhs[4:0].
  - 010: SLT, signed compare, result 1 or 0.
  - 011: SLTU, unsigned compare.
  - 100: XOR.
  - 101: SRL, or SRA (arithmetic) when alt=1.
  - 110: OR.
  - 111: AND.
  - alt is ignored for func other than 000 and 101.
  - Add/sub wrap modulo 2^32; no overflow or carry output.
- Timing: result updates on every rising clk with f(lhs,rhs,func,alt) sampled at that edge. Latency is exactly 1 cycle. There is no enable or handshake; a new operation may start every cycle.
- Reset: when reset=1 at a clk edge, result <= 0. Reset takes priority over the computation. The combinational decoder is unaffected by reset.
- Boundary cases:
  - Shift by 0 returns lhs.
  - Shift amounts ≥32 are truncated to rhs[4:0].
  - SLT 0x80000000 vs 0x7FFFFFFF = 1; SLTU of the same operands = 0.
  - ADD 0xFFFFFFFF+1 = 0.

Optional Feature:
- Macro: RV32I_ILLEGAL_DETECT_EN.
- Defined: illegal=1 combinationally when any of these holds:
  - opcode is not one of the 11 listed above.
  - inst[1:0] != 2'b11.
  - opcode is OP and funct7 is not 0000000, or not 0100000 when funct3 is 000 or 101.
- Not defined: illegal is tied to 0.
- No other behaviour changes in either case.

Test Plan:
- inst=0xFFF10093 (ADDI x1,x2,-1) -> opcode=0010011, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF.
- inst=0x123452B7 (LUI x5) -> imm=0x12345000, rd=5. inst=0xFFDFF0EF (JAL x1,-4) -> imm=0xFFFFFFFC, rd=1.
- ALU func=000: lhs=5, rhs=7, alt=1 -> result=0xFFFFFFFE one cycle later. alt=0 with lhs=0xFFFFFFFF, rhs=1 -> 0.
- func=101, lhs=0x80000000, rhs=4: alt=1 -> 0xF8000000; alt=0 -> 0x08000000. func=001, lhs=1, rhs=33 -> 2.
- func=010 vs 011, lhs=0xFFFFFFFF, rhs=1 -> 1 and 0 respectively.
- Assert reset during streaming ops -> result=0 on the next edge. First op after deassert appears 1 cycle later. With RV32I_ILLEGAL_DETECT_EN defined, inst=0x00000000 -> illegal=1.
